// File: rtl/alu_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// alu_arbiter_pkg
// Shared ALU parameters used by the arbiter, its interface and the testbench:
//   ALUWIDTH  operand/result width
//   OPSIZE    opcode width
//   NUMFLAGS  flag vector width
// The file also holds the opcode encodings and the flag bit positions of the
// shared ALU.
// ---------------------------------------------------------------------------
package alu_arbiter_pkg;

  parameter int ALUWIDTH = 16;
  parameter int OPSIZE   = 4;
  parameter int NUMFLAGS = 4;

  // Opcode encodings understood by the shared ALU
  localparam logic [OPSIZE-1:0] OP_ADD = 4'd0;
  localparam logic [OPSIZE-1:0] OP_SUB = 4'd1;
  localparam logic [OPSIZE-1:0] OP_AND = 4'd2;
  localparam logic [OPSIZE-1:0] OP_OR  = 4'd3;
  localparam logic [OPSIZE-1:0] OP_LS  = 4'd4;
  localparam logic [OPSIZE-1:0] OP_RS  = 4'd5;

  // Bit positions inside the ALU flag vector
  localparam int FLAG_C = 0;  // carry out (ADD) / borrow (SUB)
  localparam int FLAG_Z = 1;  // result is zero
  localparam int FLAG_N = 2;  // result MSB
  localparam int FLAG_V = 3;  // signed overflow

endpackage

// File: rtl/alu_arbiter_if.sv
// ---------------------------------------------------------------------------
// alu_arbiter_if
// Requester and response handshake bundle of the ALU arbiter.
//   req0_* / req1_*  : valid/ready request channels carrying opcode+operands
//   rsp_*            : valid/ready response channel carrying id, result, flags
// Modports:
//   slave  - the arbiter side (consumes requests, produces the response)
//   master - the environment side (produces requests, consumes the response)
// ---------------------------------------------------------------------------
interface alu_arbiter_if;
  import alu_arbiter_pkg::*;

  logic                req0_valid;
  logic                req0_ready;
  logic [OPSIZE-1:0]   req0_opcode;
  logic [ALUWIDTH-1:0] req0_in1;
  logic [ALUWIDTH-1:0] req0_in2;

  logic                req1_valid;
  logic                req1_ready;
  logic [OPSIZE-1:0]   req1_opcode;
  logic [ALUWIDTH-1:0] req1_in1;
  logic [ALUWIDTH-1:0] req1_in2;

  logic                rsp_valid;
  logic                rsp_ready;
  logic                rsp_id;
  logic [ALUWIDTH-1:0] rsp_out;
  logic [NUMFLAGS-1:0] rsp_flags;

  modport slave (
    input  req0_valid, req0_opcode, req0_in1, req0_in2,
    output req0_ready,
    input  req1_valid, req1_opcode, req1_in1, req1_in2,
    output req1_ready,
    output rsp_valid, rsp_id, rsp_out, rsp_flags,
    input  rsp_ready
  );

  modport master (
    output req0_valid, req0_opcode, req0_in1, req0_in2,
    input  req0_ready,
    output req1_valid, req1_opcode, req1_in1, req1_in2,
    input  req1_ready,
    input  rsp_valid, rsp_id, rsp_out, rsp_flags,
    output rsp_ready
  );

endinterface

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
// Shares one combinational ALU between two requesters. One operation is in
// flight at a time: IDLE accepts a request, EXEC drives the ALU and captures
// its result, RESP holds the result until the consumer takes it.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset
//   bus         alu_arbiter_if.slave: two request channels + response channel
//   alu_opcode  opcode to the shared ALU (registered)
//   alu_in1/2   operands to the shared ALU (registered)
//   alu_out     ALU result (combinational from the ALU)
//   alu_flags   ALU flags  (combinational from the ALU)
//   busy        high whenever the arbiter is not in IDLE
//
// Build option:
//   ALU_ARB_FIXED_PRIO_EN  requester 0 always wins contention; the round-robin
//                          last_grant register is removed.
// ---------------------------------------------------------------------------
module alu_arbiter
  import alu_arbiter_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  alu_arbiter_if.slave        bus,
  output logic [OPSIZE-1:0]   alu_opcode,
  output logic [ALUWIDTH-1:0] alu_in1,
  output logic [ALUWIDTH-1:0] alu_in2,
  input  logic [ALUWIDTH-1:0] alu_out,
  input  logic [NUMFLAGS-1:0] alu_flags,
  output logic                busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [OPSIZE-1:0]   op_q,  op_d;
  logic [ALUWIDTH-1:0] in1_q, in1_d;
  logic [ALUWIDTH-1:0] in2_q, in2_d;
  logic                id_q,  id_d;

  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_id_q,    rsp_id_d;
  logic [ALUWIDTH-1:0] rsp_out_q,   rsp_out_d;
  logic [NUMFLAGS-1:0] rsp_flags_q, rsp_flags_d;
  logic                busy_q,      busy_d;

`ifndef ALU_ARB_FIXED_PRIO_EN
  logic                last_grant_q, last_grant_d;
`endif

  logic grant_id_s;
  logic accept_s;

  // Arbitration: pick the winner among the valid requesters
  always_comb begin
    grant_id_s = 1'b0;
`ifdef ALU_ARB_FIXED_PRIO_EN
    if (bus.req0_valid) begin
      grant_id_s = 1'b0;
    end else begin
      grant_id_s = 1'b1;
    end
`else
    // On contention the requester that did not win last time goes first
    if (bus.req0_valid && bus.req1_valid) begin
      grant_id_s = ~last_grant_q;
    end else if (bus.req1_valid) begin
      grant_id_s = 1'b1;
    end else begin
      grant_id_s = 1'b0;
    end
`endif
    // rst_n gates the accept so no ready escapes during a reset cycle
    accept_s = rst_n && (state_q == IDLE) && (bus.req0_valid || bus.req1_valid);
  end

  assign bus.req0_ready = accept_s && (grant_id_s == 1'b0);
  assign bus.req1_ready = accept_s && (grant_id_s == 1'b1);

  // Next-state and register-input logic
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    in1_d       = in1_q;
    in2_d       = in2_q;
    id_d        = id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_out_d   = rsp_out_q;
    rsp_flags_d = rsp_flags_q;
`ifndef ALU_ARB_FIXED_PRIO_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d = EXEC;
          id_d    = grant_id_s;
`ifndef ALU_ARB_FIXED_PRIO_EN
          last_grant_d = grant_id_s;
`endif
          if (grant_id_s) begin
            op_d  = bus.req1_opcode;
            in1_d = bus.req1_in1;
            in2_d = bus.req1_in2;
          end else begin
            op_d  = bus.req0_opcode;
            in1_d = bus.req0_in1;
            in2_d = bus.req0_in2;
          end
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        // ALU sees op_q/in*_q this cycle; its combinational result is captured
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_id_d    = id_q;
        rsp_out_d   = alu_out;
        rsp_flags_d = alu_flags;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end else begin
          state_d     = RESP;
        end
      end
      default: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= '0;
      in1_q       <= '0;
      in2_q       <= '0;
      id_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_out_q   <= '0;
      rsp_flags_q <= '0;
      busy_q      <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      in1_q       <= in1_d;
      in2_q       <= in2_d;
      id_q        <= id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_out_q   <= rsp_out_d;
      rsp_flags_q <= rsp_flags_d;
      busy_q      <= busy_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  // ALU inputs come straight from registers so they never follow requester pins
  assign alu_opcode    = op_q;
  assign alu_in1       = in1_q;
  assign alu_in2       = in2_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_out   = rsp_out_q;
  assign bus.rsp_flags = rsp_flags_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
// Self-checking bench for alu_arbiter. A behavioural ALU stands in for the
// shared ALU. Expected values come from a transaction-level model: a single
// outstanding operation that becomes visible two cycles after acceptance and
// retires when the consumer is ready, plus the round-robin / fixed-priority
// winner rule.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic                clk;
  logic                rst_n;
  logic [OPSIZE-1:0]   alu_opcode;
  logic [ALUWIDTH-1:0] alu_in1;
  logic [ALUWIDTH-1:0] alu_in2;
  logic [ALUWIDTH-1:0] alu_out;
  logic [NUMFLAGS-1:0] alu_flags;
  logic                busy;

  int checks   = 0;
  int failures = 0;

  // model state for round-robin
  logic m_last;

  alu_arbiter_if bus_if ();

  alu_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus_if.slave),
    .alu_opcode (alu_opcode),
    .alu_in1    (alu_in1),
    .alu_in2    (alu_in2),
    .alu_out    (alu_out),
    .alu_flags  (alu_flags),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Arithmetic ALU reference: returns {flags, result}
  function automatic logic [NUMFLAGS+ALUWIDTH-1:0] ref_alu(
      input logic [OPSIZE-1:0] op, input logic [ALUWIDTH-1:0] a, input logic [ALUWIDTH-1:0] b);
    int unsigned ua, ub, sum;
    logic [ALUWIDTH-1:0] r;
    logic [NUMFLAGS-1:0] f;
    logic c, v;
    ua = a; ub = b; c = 1'b0; v = 1'b0;
    case (op)
      OP_ADD: begin sum = ua + ub; r = sum[ALUWIDTH-1:0]; c = (sum > 32'hFFFF);
                    v = (a[ALUWIDTH-1] == b[ALUWIDTH-1]) && (r[ALUWIDTH-1] != a[ALUWIDTH-1]); end
      OP_SUB: begin r = a - b; c = (ua < ub);
                    v = (a[ALUWIDTH-1] != b[ALUWIDTH-1]) && (r[ALUWIDTH-1] != a[ALUWIDTH-1]); end
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_LS:  r = a << b[3:0];
      OP_RS:  r = a >> b[3:0];
      default: r = '0;
    endcase
    f = '0;
    f[FLAG_C] = c;
    f[FLAG_Z] = (r == '0);
    f[FLAG_N] = r[ALUWIDTH-1];
    f[FLAG_V] = v;
    return {f, r};
  endfunction

  // Stand-in for the shared combinational ALU
  always_comb begin
    {alu_flags, alu_out} = ref_alu(alu_opcode, alu_in1, alu_in2);
  end

  // Winner rule among valid requesters
  function automatic logic pick(input logic v0, input logic v1, input logic last);
`ifdef ALU_ARB_FIXED_PRIO_EN
    return v0 ? 1'b0 : 1'b1;
`else
    if (v0 && v1) return ~last;
    return v1;
`endif
  endfunction

  task automatic idle_inputs();
    bus_if.req0_valid = 1'b0; bus_if.req0_opcode = '0; bus_if.req0_in1 = '0; bus_if.req0_in2 = '0;
    bus_if.req1_valid = 1'b0; bus_if.req1_opcode = '0; bus_if.req1_in1 = '0; bus_if.req1_in2 = '0;
    bus_if.rsp_ready  = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    m_last = 1'b1;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    bus_if.req0_valid = 1'b0;
    bus_if.req1_valid = 1'b0;
    bus_if.rsp_ready  = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk); #1;
      if (!busy && !bus_if.rsp_valid) done = 1'b1;
    end
    checks++;
    if (!done) begin failures++; $display("FAIL drain_timeout: busy=%0b rsp_valid=%0b required idle", busy, bus_if.rsp_valid); end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus_if.req0_valid = 1'b1; bus_if.req0_opcode = OP_OR; bus_if.req0_in1 = 16'h1234; bus_if.req0_in2 = 16'h00FF;
    bus_if.req1_valid = 1'b1; bus_if.req1_opcode = OP_AND; bus_if.req1_in1 = 16'hFFFF; bus_if.req1_in2 = 16'hFFFF;
    bus_if.rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      checks++; if ({bus_if.req0_ready, bus_if.req1_ready} !== 2'b00) begin failures++; $display("FAIL reset_ready: got %b required 00", {bus_if.req0_ready, bus_if.req1_ready}); end
      checks++; if (bus_if.rsp_valid !== 1'b0 || bus_if.rsp_id !== 1'b0) begin failures++; $display("FAIL reset_rsp_ctl: got valid=%b id=%b required 0/0", bus_if.rsp_valid, bus_if.rsp_id); end
      checks++; if (bus_if.rsp_out !== 16'h0000 || bus_if.rsp_flags !== 4'h0) begin failures++; $display("FAIL reset_rsp_data: got %h/%h required 0000/0", bus_if.rsp_out, bus_if.rsp_flags); end
      checks++; if (alu_opcode !== 4'h0 || alu_in1 !== 16'h0000 || alu_in2 !== 16'h0000) begin failures++; $display("FAIL reset_alu: got %h %h %h required zeros", alu_opcode, alu_in1, alu_in2); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b required 0", busy); end
    end
    @(negedge clk);
    rst_n = 1'b1; m_last = 1'b1;
    #1;
    checks++; if ({bus_if.req0_ready, bus_if.req1_ready} !== 2'b10) begin failures++; $display("FAIL reset_first_grant: got r0r1=%b required 10", {bus_if.req0_ready, bus_if.req1_ready}); end
    drain();
  endtask

  task automatic test_single_op();
    apply_reset();
    bus_if.req0_valid = 1'b1; bus_if.req0_opcode = OP_ADD; bus_if.req0_in1 = 16'h8000; bus_if.req0_in2 = 16'h8000;
    #1;
    checks++; if (bus_if.req0_ready !== 1'b1) begin failures++; $display("FAIL single_accept: got %b required 1", bus_if.req0_ready); end
    @(negedge clk);
    bus_if.req0_valid = 1'b0;
    #1;
    checks++; if (bus_if.rsp_valid !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL single_exec: got valid=%b busy=%b required 0/1", bus_if.rsp_valid, busy); end
    checks++; if (alu_opcode !== OP_ADD || alu_in1 !== 16'h8000 || alu_in2 !== 16'h8000) begin failures++; $display("FAIL single_alu_drive: got %h %h %h required 0 8000 8000", alu_opcode, alu_in1, alu_in2); end
    @(negedge clk); #1;
    checks++; if (bus_if.rsp_valid !== 1'b1) begin failures++; $display("FAIL single_latency: got rsp_valid=%b required 1 at N+2", bus_if.rsp_valid); end
    checks++; if (bus_if.rsp_out !== 16'h0000 || bus_if.rsp_id !== 1'b0) begin failures++; $display("FAIL single_result: got out=%h id=%b required 0000/0", bus_if.rsp_out, bus_if.rsp_id); end
    checks++; if (bus_if.rsp_flags[FLAG_C] !== 1'b1) begin failures++; $display("FAIL single_carry: got flags=%b required carry set", bus_if.rsp_flags); end
    bus_if.rsp_ready = 1'b1;
    @(negedge clk); #1;
    checks++; if (bus_if.rsp_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL single_retire: got valid=%b busy=%b required 0/0", bus_if.rsp_valid, busy); end
    drain();
  endtask

  task automatic test_contention();
    int gcyc[$];
    logic gid[$];
    logic exp_id;
    apply_reset();
    bus_if.req0_valid = 1'b1; bus_if.req0_opcode = OP_SUB; bus_if.req0_in1 = 16'd5;     bus_if.req0_in2 = 16'd3;
    bus_if.req1_valid = 1'b1; bus_if.req1_opcode = OP_AND; bus_if.req1_in1 = 16'hF0F0; bus_if.req1_in2 = 16'h0FF0;
    bus_if.rsp_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      checks++; if (bus_if.req0_ready && bus_if.req1_ready) begin failures++; $display("FAIL cont_double_ready: cycle %0d both ready required at most one", c); end
      if (bus_if.req0_ready) begin gcyc.push_back(c); gid.push_back(1'b0); end
      if (bus_if.req1_ready) begin gcyc.push_back(c); gid.push_back(1'b1); end
      if (bus_if.rsp_valid) begin
        checks++;
        if (bus_if.rsp_out !== (bus_if.rsp_id ? 16'h00F0 : 16'h0002)) begin
          failures++; $display("FAIL cont_result: id=%b got %h required %h", bus_if.rsp_id, bus_if.rsp_out, bus_if.rsp_id ? 16'h00F0 : 16'h0002);
        end
      end
    end
    checks++; if (gid.size() != 4) begin failures++; $display("FAIL cont_grant_count: got %0d required 4", gid.size()); end
    exp_id = m_last;
    for (int k = 0; k < gid.size() && k < 4; k++) begin
      exp_id = pick(1'b1, 1'b1, exp_id);
      checks++; if (gid[k] !== exp_id) begin failures++; $display("FAIL cont_grant_order: grant %0d got %b required %b", k, gid[k], exp_id); end
      checks++; if (gcyc[k] != 3 * k) begin failures++; $display("FAIL cont_spacing: grant %0d at cycle %0d required %0d", k, gcyc[k], 3 * k); end
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic [ALUWIDTH-1:0] a, b;
    logic [NUMFLAGS+ALUWIDTH-1:0] exp;
    apply_reset();
    a = ALUWIDTH'($urandom); b = ALUWIDTH'($urandom);
    exp = ref_alu(OP_OR, a, b);
    bus_if.req1_valid = 1'b1; bus_if.req1_opcode = OP_OR; bus_if.req1_in1 = a; bus_if.req1_in2 = b;
    #1;
    checks++; if (bus_if.req1_ready !== 1'b1) begin failures++; $display("FAIL bp_accept: got %b required 1", bus_if.req1_ready); end
    @(negedge clk);
    bus_if.req0_valid = 1'b1; bus_if.req0_opcode = OP_ADD; bus_if.req0_in1 = 16'h0001; bus_if.req0_in2 = 16'h0001;
    bus_if.req1_in1 = ~a;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      checks++; if (bus_if.rsp_valid !== 1'b1 || bus_if.rsp_id !== 1'b1) begin failures++; $display("FAIL bp_hold_ctl: cycle %0d valid=%b id=%b required 1/1", i, bus_if.rsp_valid, bus_if.rsp_id); end
      checks++; if ({bus_if.rsp_flags, bus_if.rsp_out} !== exp) begin failures++; $display("FAIL bp_hold_data: cycle %0d got %h required %h", i, {bus_if.rsp_flags, bus_if.rsp_out}, exp); end
      checks++; if ({bus_if.req0_ready, bus_if.req1_ready} !== 2'b00) begin failures++; $display("FAIL bp_ready: cycle %0d got %b required 00", i, {bus_if.req0_ready, bus_if.req1_ready}); end
    end
    bus_if.rsp_ready = 1'b1;
    @(negedge clk); #1;
    checks++; if (busy !== 1'b0 || bus_if.rsp_valid !== 1'b0) begin failures++; $display("FAIL bp_release: busy=%b valid=%b required 0/0", busy, bus_if.rsp_valid); end
    checks++; if ({bus_if.req0_ready, bus_if.req1_ready} !== 2'b10) begin failures++; $display("FAIL bp_next_grant: got %b required 10", {bus_if.req0_ready, bus_if.req1_ready}); end
    drain();
  endtask

  task automatic test_midop_reset();
    apply_reset();
    bus_if.req0_valid = 1'b1; bus_if.req0_opcode = OP_ADD; bus_if.req0_in1 = 16'h0010; bus_if.req0_in2 = 16'h0020;
    #1;
    checks++; if (bus_if.req0_ready !== 1'b1) begin failures++; $display("FAIL mid_accept: got %b required 1", bus_if.req0_ready); end
    @(negedge clk);
    rst_n = 1'b0;
    bus_if.req0_valid = 1'b1; bus_if.req1_valid = 1'b1; bus_if.rsp_ready = 1'b0;
    #1;
    checks++; if ({bus_if.req0_ready, bus_if.req1_ready} !== 2'b00) begin failures++; $display("FAIL mid_ready_in_reset: got %b required 00", {bus_if.req0_ready, bus_if.req1_ready}); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      checks++; if (bus_if.rsp_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL mid_abort: cycle %0d valid=%b busy=%b required 0/0", i, bus_if.rsp_valid, busy); end
      checks++; if ({bus_if.req0_ready, bus_if.req1_ready} !== 2'b00) begin failures++; $display("FAIL mid_ready_hold: cycle %0d got %b required 00", i, {bus_if.req0_ready, bus_if.req1_ready}); end
    end
    rst_n = 1'b1; m_last = 1'b1;
    #1;
    checks++; if ({bus_if.req0_ready, bus_if.req1_ready} !== 2'b10) begin failures++; $display("FAIL mid_next_grant: got %b required 10", {bus_if.req0_ready, bus_if.req1_ready}); end
    drain();
  endtask

  task automatic test_random();
    logic m_busy, m_have, m_id, win, v0, v1;
    int   m_age;
    logic [OPSIZE-1:0]   m_op, op0, op1;
    logic [ALUWIDTH-1:0] m_a, m_b, a0, b0, a1, b1;
    logic [NUMFLAGS+ALUWIDTH-1:0] m_res;
    apply_reset();
    m_busy = 1'b0; m_have = 1'b0; m_age = 0; m_id = 1'b0;
    m_op = '0; m_a = '0; m_b = '0; m_res = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc > 0) @(negedge clk);
      v0 = ($urandom_range(0, 3) != 0); v1 = ($urandom_range(0, 2) != 0);
      op0 = OPSIZE'($urandom_range(0, 6)); op1 = OPSIZE'($urandom_range(0, 6));
      a0 = ALUWIDTH'($urandom); b0 = ALUWIDTH'($urandom); a1 = ALUWIDTH'($urandom); b1 = ALUWIDTH'($urandom);
      bus_if.req0_valid = v0; bus_if.req0_opcode = op0; bus_if.req0_in1 = a0; bus_if.req0_in2 = b0;
      bus_if.req1_valid = v1; bus_if.req1_opcode = op1; bus_if.req1_in1 = a1; bus_if.req1_in2 = b1;
      bus_if.rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      win = pick(v0, v1, m_last);
      checks++;
      if (bus_if.req0_ready !== (!m_busy && v0 && !win) || bus_if.req1_ready !== (!m_busy && v1 && win)) begin
        failures++; $display("FAIL rand_ready: cycle %0d got %b%b required %b%b", cyc, bus_if.req0_ready, bus_if.req1_ready, !m_busy && v0 && !win, !m_busy && v1 && win);
      end
      checks++;
      if (busy !== m_busy || bus_if.rsp_valid !== (m_busy && m_age >= 2)) begin
        failures++; $display("FAIL rand_status: cycle %0d busy=%b valid=%b required %b/%b", cyc, busy, bus_if.rsp_valid, m_busy, m_busy && m_age >= 2);
      end
      if (m_busy && m_age >= 2) begin
        checks++;
        if (bus_if.rsp_id !== m_id || {bus_if.rsp_flags, bus_if.rsp_out} !== m_res) begin
          failures++; $display("FAIL rand_rsp: cycle %0d got id=%b %h required id=%b %h", cyc, bus_if.rsp_id, {bus_if.rsp_flags, bus_if.rsp_out}, m_id, m_res);
        end
      end
      if (m_have) begin
        checks++;
        if (alu_opcode !== m_op || alu_in1 !== m_a || alu_in2 !== m_b) begin
          failures++; $display("FAIL rand_alu_hold: cycle %0d got %h %h %h required %h %h %h", cyc, alu_opcode, alu_in1, alu_in2, m_op, m_a, m_b);
        end
      end
      if (!m_busy) begin
        if (v0 || v1) begin
          m_busy = 1'b1; m_age = 1; m_last = win; m_id = win; m_have = 1'b1;
          m_op = win ? op1 : op0; m_a = win ? a1 : a0; m_b = win ? b1 : b0;
          m_res = ref_alu(m_op, m_a, m_b);
        end
      end else if (m_age >= 2 && bus_if.rsp_ready) begin
        m_busy = 1'b0;
      end else begin
        m_age++;
      end
    end
    drain();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    m_last = 1'b1;
    idle_inputs();
    test_reset();
    test_single_op();
    test_contention();
    test_backpressure();
    test_midop_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameters SHALL come from the shared parameters include: aluwidth, default 16, operand/result width; opsize, default 4, opcode width; numflags, default 4, flag width.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset; one clock; reset is synchronous and active-low.
REQ-004 req0_valid / req1_valid  input  1  requester k has an ALU operation pending.
REQ-005 req0_ready / req1_ready  output  1  requester k's operation is accepted this cycle.
REQ-006 req0_opcode / req1_opcode  input  opsize  ALU opcode (ADD, SUB, AND, OR, LS, RS encodings from the shared include).
REQ-007 req0_in1, req0_in2 / req1_in1, req1_in2  input  aluwidth  operands.
REQ-008 rsp_valid  output  1  result held on rsp_* outputs.
REQ-009 rsp_ready  input  1  consumer accepts the result.
REQ-010 rsp_id  output  1  index of the requester owning the result.
REQ-011 rsp_out  output  aluwidth  captured ALU result.
REQ-012 rsp_flags  output  numflags  captured ALU flags.
REQ-013 alu_opcode, alu_in1, alu_in2  output  opsize/aluwidth/aluwidth  driven to the shared ALUmodule.
REQ-014 alu_out, alu_flags  input  aluwidth/numflags  from the shared ALUmodule (combinational).
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, EXEC, RESP.
REQ-017 IDLE: if any reqk_valid, the winner's reqk_ready SHALL assert combinationally in that cycle, its opcode/operands/id SHALL be registered, and the next state SHALL be EXEC; otherwise stay IDLE.
REQ-018 reqk_ready SHALL only be high in IDLE, for at most one requester, and only when that reqk_valid is high.
REQ-019 EXEC: alu_opcode/alu_in1/alu_in2 SHALL be driven from the registered operands; at the end of the cycle alu_out/alu_flags SHALL be captured into rsp_out/rsp_flags and the next state SHALL be RESP.
REQ-020 RESP: rsp_valid SHALL be 1 and rsp_out/rsp_flags/rsp_id SHALL be held stable until rsp_ready is sampled high, then next state IDLE.
REQ-021 Latency: handshake in cycle N SHALL give rsp_valid in cycle N+2; with rsp_ready held high, minimum spacing between accepts SHALL be 3 cycles.
REQ-022 Outside EXEC, alu_* outputs SHALL hold the last registered values (no glitching to requester inputs).
REQ-023 Arbitration (default): round-robin; a 1-bit last_grant register SHALL update on every accept; when both valid, the requester not equal to last_grant SHALL win; when one valid, it SHALL win regardless of last_grant.
REQ-024 Requester inputs SHALL be ignored outside IDLE; a requester dropping valid before ready SHALL simply not be served.
REQ-025 No width extension: rsp_out SHALL equal alu_out bit-for-bit; carry/overflow are reported only through flags.

Reset
REQ-026 On rst_n low at a rising edge: state IDLE, last_grant 1 (requester 0 wins first contention), rsp_valid 0, rsp_id 0, rsp_out 0, rsp_flags 0, alu_* registers 0, busy 0.
REQ-027 Reset in EXEC or RESP SHALL abort the operation; no rsp_valid SHALL follow for it.
REQ-028 reqk_ready SHALL be 0 during any cycle where rst_n is low.

Configuration
REQ-029 Macro ALU_ARB_FIXED_PRIO_EN: when defined, requester 0 SHALL always win contention and last_grant SHALL be absent; when undefined, round-robin per REQ-023 applies.

Verification
REQ-030 Reset: hold rst_n=0 with both valids high -> all outputs 0, no ready; release -> req0_ready in first IDLE cycle.
REQ-031 Single op: req0 ADD in1=0x8000 in2=0x8000 -> rsp_valid at N+2, rsp_out=0x0000, rsp_id=0, carry flag set.
REQ-032 Contention: both valid continuously, rsp_ready=1, req0 SUB 5-3, req1 AND 0xF0F0&0x0FF0 -> grants alternate 0,1,0,1; results 0x0002 and 0x00F0.
REQ-033 Backpressure: rsp_ready=0 for 10 cycles in RESP -> rsp_* stable, no ready to either requester; rsp_ready=1 -> IDLE next cycle.
REQ-034 Mid-op reset: rst_n=0 during EXEC -> no rsp_valid afterwards; next grant goes to requester 0.
REQ-035 With ALU_ARB_FIXED_PRIO_EN defined and both valid -> requester 0 granted every time, req1_ready never high.
